mem_arbiter: RTL and testbench

- Arbitrates one single-port unified memory between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between the cpu top level and the memory macro, in place of the direct code-memory hookup.
- Sequences each access through a fixed-latency memory transaction and returns data with a one-cycle valid pulse.
- Raises a stall flag so the PC/writeback logic can hold while an access is pending.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between instruction fetch (IF) and load/store (LS).
// Optional macro ARB_ROUND_ROBIN_EN alternates grants on contention; default is fixed LS-over-IF priority.
module mem_arbiter #(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_rvalid,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   state_t            state, state_nxt;
   logic              owner_q;          // 1 = LS, 0 = IF
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        cnt_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ls_rdata_q;
   logic              grant_any;
   logic              grant_ls;

   // Grant is combinational in IDLE; it is masked while reset is held so outputs read 0.
   assign grant_any = (if_req | ls_req) & (state == IDLE) & ~reset;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_owner_q <= 1'b0;
      end else if (grant_any) begin
         last_owner_q <= grant_ls;
      end
   end

   // On contention the requester that was not served last wins.
   assign grant_ls = ls_req & (~if_req | ~last_owner_q);
`else
   assign grant_ls = ls_req;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt_q == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= 4'd0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner_q <= grant_ls;
                  we_q    <= grant_ls & ls_we;
                  addr_q  <= grant_ls ? ls_addr : if_addr;
                  wdata_q <= grant_ls ? ls_wdata : '0;
               end
            end
            ISSUE: cnt_q <= CNT_LOAD;
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  // Stores complete with a pulse but leave the load data register untouched.
                  if (owner_q) begin
                     if (!we_q) ls_rdata_q <= mem_rdata;
                  end else begin
                     if_rdata_q <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign if_gnt    = grant_any & ~grant_ls;
   assign ls_gnt    = grant_any & grant_ls;
   assign if_rvalid = (state == RESP) & ~owner_q;
   assign ls_rvalid = (state == RESP) & owner_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   assign mem_en    = (state == ISSUE);
   assign mem_we    = we_q & ((state == ISSUE) | (state == WAIT));
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign stall     = ~reset & ((state != IDLE) | ((if_req | ls_req) & ~grant_any));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
   localparam int LAT = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
`ifdef ARB_ROUND_ROBIN_EN
   localparam int NG = 4;
`else
   localparam int NG = 2;
`endif

   logic          clk;
   logic          reset;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          ls_req, ls_we, ls_gnt, ls_rvalid;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata, ls_rdata;
   logic          mem_en, mem_we, stall;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0b, expected %0b", name, $time, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Memory macro: synchronous array, read data appears LAT cycles after mem_en.
   logic [DW-1:0] env_mem [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] rd_pipe [LAT];
   assign mem_rdata = rd_pipe[LAT-1];

   initial begin
      logic [DW-1:0] nxt;
      for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'h0BAD_F00D;
      forever begin
         @(posedge clk);
         nxt = 32'h0BAD_F00D;
         if (mem_en) begin
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            else nxt = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
         end
         for (int i = LAT-1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
         rd_pipe[0] <= nxt;
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      env_mem[a] = d;
      ref_mem[a] = d;
   endtask

   // Transaction-level model: each access occupies offsets k = 0 (grant) .. LAT+2 (response).
   logic          m_active = 1'b0;
   int            m_k = 0;
   logic          m_owner, m_we, m_last;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_val;
   logic [DW-1:0] m_if_rd = '0, m_ls_rd = '0;

   initial begin
      logic e_ifg, e_lsg, e_en, e_we, e_ifv, e_lsv, e_stall;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk1("rst_if_gnt", if_gnt, 1'b0);      chk1("rst_ls_gnt", ls_gnt, 1'b0);
            chk1("rst_if_rvalid", if_rvalid, 1'b0); chk1("rst_ls_rvalid", ls_rvalid, 1'b0);
            chk1("rst_mem_en", mem_en, 1'b0);       chk1("rst_mem_we", mem_we, 1'b0);
            chk1("rst_stall", stall, 1'b0);
            chkw("rst_mem_addr", mem_addr, '0);     chkw("rst_mem_wdata", mem_wdata, '0);
            chkw("rst_if_rdata", if_rdata, '0);     chkw("rst_ls_rdata", ls_rdata, '0);
            m_active = 1'b0; m_k = 0; m_if_rd = '0; m_ls_rd = '0; m_last = 1'b0;
         end else begin
            e_ifg = 1'b0; e_lsg = 1'b0; e_en = 1'b0; e_we = 1'b0;
            e_ifv = 1'b0; e_lsv = 1'b0; e_stall = 1'b0;
            if (m_active) begin
               m_k++;
               if (m_k == LAT+3) m_active = 1'b0;
            end
            if (!m_active) begin
               if (if_req || ls_req) begin
                  m_owner = ls_req;
`ifdef ARB_ROUND_ROBIN_EN
                  if (if_req && ls_req) m_owner = ~m_last;
`endif
                  m_last = m_owner; m_active = 1'b1; m_k = 0;
                  m_we = m_owner & ls_we;
                  m_addr = m_owner ? ls_addr : if_addr;
                  m_wdata = ls_wdata;
                  e_ifg = ~m_owner; e_lsg = m_owner;
               end
            end else begin
               e_stall = 1'b1;
               if (m_k == 1) begin
                  e_en = 1'b1;
                  if (m_we) ref_mem[m_addr] = m_wdata;
                  else m_val = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_word(m_addr);
               end
               if (m_k <= LAT+1) begin
                  e_we = m_we;
                  chkw("mem_addr", mem_addr, m_addr);
                  if (m_we) chkw("mem_wdata", mem_wdata, m_wdata);
               end
               if (m_k == LAT+2) begin
                  if (m_owner) begin
                     e_lsv = 1'b1;
                     if (!m_we) m_ls_rd = m_val;
                  end else begin
                     e_ifv = 1'b1;
                     m_if_rd = m_val;
                  end
               end
            end
            chk1("if_gnt", if_gnt, e_ifg);       chk1("ls_gnt", ls_gnt, e_lsg);
            chk1("mem_en", mem_en, e_en);        chk1("mem_we", mem_we, e_we);
            chk1("if_rvalid", if_rvalid, e_ifv); chk1("ls_rvalid", ls_rvalid, e_lsv);
            chk1("stall", stall, e_stall);
            chkw("if_rdata", if_rdata, m_if_rd); chkw("ls_rdata", ls_rdata, m_ls_rd);
         end
      end
   end

   task automatic if_txn(input logic [AW-1:0] addr, input logic [DW-1:0] exp_rd);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = addr;
      @(negedge clk);
      chk1("if_gnt_k0", if_gnt, 1'b1);
      @(posedge clk); #1 if_req = 1'b0;
      @(negedge clk);
      chk1("if_mem_en_k1", mem_en, 1'b1);
      chk1("if_mem_we_k1", mem_we, 1'b0);
      chkw("if_mem_addr_k1", mem_addr, addr);
      repeat (LAT) @(negedge clk);
      chk1("if_rvalid_early", if_rvalid, 1'b0);
      chk1("if_stall_wait", stall, 1'b1);
      @(negedge clk);
      chk1("if_rvalid_k", if_rvalid, 1'b1);
      chkw("if_rdata_k", if_rdata, exp_rd);
      @(negedge clk);
      chk1("if_rvalid_end", if_rvalid, 1'b0);
      chk1("if_stall_idle", stall, 1'b0);
   endtask

   task automatic ls_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rd);
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
      @(negedge clk);
      chk1("ls_gnt_k0", ls_gnt, 1'b1);
      @(posedge clk); #1 ls_req = 1'b0;
      @(negedge clk);
      chk1("ls_mem_en_k1", mem_en, 1'b1);
      chk1("ls_mem_we_k1", mem_we, we);
      chkw("ls_mem_addr_k1", mem_addr, addr);
      if (we) chkw("ls_mem_wdata_k1", mem_wdata, wdata);
      repeat (LAT) @(negedge clk);
      chk1("ls_rvalid_early", ls_rvalid, 1'b0);
      chk1("ls_stall_wait", stall, 1'b1);
      @(negedge clk);
      chk1("ls_rvalid_k", ls_rvalid, 1'b1);
      chkw("ls_rdata_k", ls_rdata, exp_rd);
      @(negedge clk);
      chk1("ls_rvalid_end", ls_rvalid, 1'b0);
      chk1("ls_stall_idle", stall, 1'b0);
   endtask

   initial begin
      int   order[$];
      int   gcyc[$];
      logic g_if, g_ls;
      int   n_en, n_g, nv, exp_o;

      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
      preload(32'h10, 32'hE3A0_1005);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;

      // Single fetch, then store/load round trip.
      if_txn(32'h10, 32'hE3A0_1005);
      ls_txn(1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0);
      ls_txn(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);

      // Reset during WAIT of a load.
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
      @(negedge clk);
      chk1("t5_ls_gnt", ls_gnt, 1'b1);
      @(posedge clk); #1 ls_req = 1'b0;
      @(posedge clk);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chkw("t5_async_ctrl", {25'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, stall}, 32'd0);
      chkw("t5_async_addr", mem_addr, '0);
      chkw("t5_async_ls_rdata", ls_rdata, '0);
      @(posedge clk); #1 reset = 1'b0;
      nv = 0;
      repeat (LAT+4) begin
         @(negedge clk);
         nv += int'(ls_rvalid);
      end
      chkw("t5_no_rvalid_after_reset", 32'(nv), 32'd0);

      // Both requesters contending.
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
      if_req = 1'b1; if_addr = 32'h20;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         g_ls = ls_gnt; g_if = if_gnt;
         if (g_ls) begin order.push_back(1); gcyc.push_back(c); end
         if (g_if) begin order.push_back(0); gcyc.push_back(c); end
         @(posedge clk); #1;
         if (order.size() >= NG) begin
            ls_req = 1'b0; if_req = 1'b0;
            break;
         end
`ifndef ARB_ROUND_ROBIN_EN
         if (g_ls) ls_req = 1'b0;
`endif
      end
      chkw("arb_grant_count", 32'(order.size()), 32'(NG));
      for (int i = 0; i < order.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_o = (i % 2 == 0) ? 1 : 0;
`else
         exp_o = (i == 0) ? 1 : 0;
`endif
         chkw("arb_order_ls1_if0", 32'(order[i]), 32'(exp_o));
         if (i > 0) chkw("arb_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(LAT+3));
      end
      repeat (LAT+3) @(negedge clk);

      // Fresh load after the reset still returns the stored word.
      ls_txn(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);

      // LS pulse while IF is busy is withdrawn before IDLE.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h20;
      @(negedge clk);
      chk1("t6_if_gnt", if_gnt, 1'b1);
      @(posedge clk); #1 if_req = 1'b0;
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
      @(posedge clk); #1 ls_req = 1'b0;
      n_en = 0; n_g = 0;
      for (int k = 3; k <= LAT+4; k++) begin
         @(negedge clk);
         n_en += int'(mem_en);
         n_g  += int'(ls_gnt);
         if (k == LAT+2) chk1("t6_if_rvalid", if_rvalid, 1'b1);
         if (k == LAT+3) chk1("t6_stall_after", stall, 1'b0);
      end
      chkw("t6_extra_mem_en", 32'(n_en), 32'd0);
      chkw("t6_withdrawn_ls_gnt", 32'(n_g), 32'd0);

      // Randomized traffic with holds, withdrawals and one mid-run reset.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g_if = if_gnt; g_ls = ls_gnt;
         @(posedge clk); #1;
         if (c == 1500) begin
            reset = 1'b1; if_req = 1'b0; ls_req = 1'b0;
            @(posedge clk); #1 reset = 1'b0;
            continue;
         end
         if (if_req) begin
            if (g_if || $urandom_range(0, 19) == 0) if_req = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1'b1;
            if_addr = 32'($urandom_range(0, 15)) << 2;
         end
         if (ls_req) begin
            if (g_ls || $urandom_range(0, 19) == 0) ls_req = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            ls_req = 1'b1;
            ls_we = 1'($urandom_range(0, 1));
            ls_addr = 32'($urandom_range(0, 15)) << 2;
            ls_wdata = $urandom;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0; ls_req = 1'b0;
      repeat (LAT+4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
